// File: rtl/alu_branch_exec_pkg.sv
// Shared constants for the execute stage: datapath width, shift-amount width
// and the ALU operation encodings used by the control FSM.
package alu_branch_exec_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int ALU_CTRL_W    = 4;
   localparam int SHAMT_W       = 5;

   localparam logic [ALU_CTRL_W-1:0] ALU_ADD   = 4'd0;
   localparam logic [ALU_CTRL_W-1:0] ALU_SUB   = 4'd1;
   localparam logic [ALU_CTRL_W-1:0] ALU_AND   = 4'd2;
   localparam logic [ALU_CTRL_W-1:0] ALU_OR    = 4'd3;
   localparam logic [ALU_CTRL_W-1:0] ALU_XOR   = 4'd4;
   localparam logic [ALU_CTRL_W-1:0] ALU_NOR   = 4'd5;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLL   = 4'd6;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRL   = 4'd7;
   localparam logic [ALU_CTRL_W-1:0] ALU_SRA   = 4'd8;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLT   = 4'd9;
   localparam logic [ALU_CTRL_W-1:0] ALU_SLTU  = 4'd10;
   localparam logic [ALU_CTRL_W-1:0] ALU_MUL   = 4'd11;
   localparam logic [ALU_CTRL_W-1:0] ALU_MULU  = 4'd12;
   localparam logic [ALU_CTRL_W-1:0] ALU_SNE   = 4'd13;
   localparam logic [ALU_CTRL_W-1:0] ALU_LUI   = 4'd14;
   localparam logic [ALU_CTRL_W-1:0] ALU_PASSB = 4'd15;

endpackage

// File: rtl/alu_branch_exec_alu_core.sv
// Registered ALU with HI/LO product registers; results and flags are captured
// on every enabled edge and held while the enable is low.
module alu_core
   import alu_branch_exec_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int CTRL_W = ALU_CTRL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_en,
   input  logic [CTRL_W-1:0] alu_control,
   input  logic [WIDTH-1:0]  src_a,
   input  logic [WIDTH-1:0]  src_b,
   output logic [WIDTH-1:0]  alu_result,
   output logic [WIDTH-1:0]  hi,
   output logic [WIDTH-1:0]  lo,
   output logic              overflow,
   output logic              alu_zero,
   output logic              alu_done
);

   logic [WIDTH-1:0]   result_d, result_q, hi_q, lo_q;
   logic               ovf_d, ovf_q, zero_q, done_q, hilo_wr_d;
   logic [WIDTH-1:0]   sum, diff;
   logic [2*WIDTH-1:0] prod_s, prod_u, prod_d;
   logic signed [WIDTH-1:0] b_signed;

   // Products are formed at double width from explicitly extended operands.
   assign sum      = src_a + src_b;
   assign diff     = src_a - src_b;
   assign prod_s   = {{WIDTH{src_a[WIDTH-1]}}, src_a} * {{WIDTH{src_b[WIDTH-1]}}, src_b};
   assign prod_u   = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
   assign b_signed = src_b;

   always_comb begin
      result_d  = '0;
      ovf_d     = 1'b0;
      hilo_wr_d = 1'b0;
      prod_d    = prod_u;
      case (alu_control)
         ALU_ADD: begin
            result_d = sum;
            ovf_d    = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
         end
         ALU_SUB: begin
            result_d = diff;
            ovf_d    = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
         end
         ALU_AND:  result_d = src_a & src_b;
         ALU_OR:   result_d = src_a | src_b;
         ALU_XOR:  result_d = src_a ^ src_b;
         ALU_NOR:  result_d = ~(src_a | src_b);
         ALU_SLL:  result_d = src_b << src_a[SHAMT_W-1:0];
         ALU_SRL:  result_d = src_b >> src_a[SHAMT_W-1:0];
         ALU_SRA:  result_d = b_signed >>> src_a[SHAMT_W-1:0];
         ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         ALU_SLTU: result_d = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
         ALU_MUL: begin
            prod_d    = prod_s;
            result_d  = prod_s[WIDTH-1:0];
            hilo_wr_d = 1'b1;
         end
         ALU_MULU: begin
            prod_d    = prod_u;
            result_d  = prod_u[WIDTH-1:0];
            hilo_wr_d = 1'b1;
         end
         // Inverted equality so alu_zero is set on inequality, serving bne.
         ALU_SNE:  result_d = {{(WIDTH-1){1'b0}}, (src_a == src_b)};
         ALU_LUI:  result_d = src_b << 16;
         ALU_PASSB: result_d = src_b;
         default:  result_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result_q <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (alu_en) begin
         result_q <= result_d;
         ovf_q    <= ovf_d;
         zero_q   <= (result_d == '0);
         done_q   <= 1'b1;
         if (hilo_wr_d) begin
            hi_q <= prod_d[2*WIDTH-1:WIDTH];
            lo_q <= prod_d[WIDTH-1:0];
         end
      end else begin
         done_q <= 1'b0;
      end
   end

   assign alu_result = result_q;
   assign hi         = hi_q;
   assign lo         = lo_q;
   assign overflow   = ovf_q;
   assign alu_zero   = zero_q;
   assign alu_done   = done_q;

endmodule

// File: rtl/alu_branch_exec.sv
// Execute stage: source-A select, registered ALU and the branch-target unit
// that resolves the next PC from the previously registered zero flag.
module alu_branch_exec
   import alu_branch_exec_pkg::*;
#(
   parameter int WIDTH  = DEFAULT_WIDTH,
   parameter int CTRL_W = ALU_CTRL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_en,
   input  logic [CTRL_W-1:0] alu_control,
   input  logic [WIDTH-1:0]  read_data1,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic              select_shamt,
   input  logic [WIDTH-1:0]  alu_srcB,
   output logic [WIDTH-1:0]  alu_srcA,
   output logic [WIDTH-1:0]  alu_result,
   output logic [WIDTH-1:0]  hi,
   output logic [WIDTH-1:0]  lo,
   output logic              overflow,
   output logic              alu_zero,
   output logic              alu_done,
   input  logic              branch_en,
   input  logic              branch,
   input  logic [WIDTH-1:0]  imm,
   input  logic [WIDTH-1:0]  pc,
   output logic [WIDTH-1:0]  pc_out,
   output logic              branch_done
);

   logic [WIDTH-1:0] pc_out_q;
   logic             branch_done_q;

   assign alu_srcA = select_shamt ? {{(WIDTH-SHAMT_W){1'b0}}, shamt} : read_data1;

   alu_core #(
      .WIDTH  (WIDTH),
      .CTRL_W (CTRL_W)
   ) u_alu_core (
      .clk         (clk),
      .rst         (rst),
      .alu_en      (alu_en),
      .alu_control (alu_control),
      .src_a       (alu_srcA),
      .src_b       (alu_srcB),
      .alu_result  (alu_result),
      .hi          (hi),
      .lo          (lo),
      .overflow    (overflow),
      .alu_zero    (alu_zero),
      .alu_done    (alu_done)
   );

   // alu_zero is a register output, so a same-edge ALU update is not seen here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_out_q      <= '0;
         branch_done_q <= 1'b0;
      end else if (branch_en) begin
         pc_out_q      <= (branch && alu_zero) ? (pc + imm) : pc;
         branch_done_q <= 1'b1;
      end else begin
         branch_done_q <= 1'b0;
      end
   end

   assign pc_out      = pc_out_q;
   assign branch_done = branch_done_q;

endmodule

// File: tb/tb_alu_branch_exec.sv
// Directed self-checking bench for the execute stage with hand-computed
// expectations for ALU ops, HI/LO, branch resolution and async reset.
module tb_alu_branch_exec;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_en;
   logic [3:0]  alu_control;
   logic [31:0] read_data1;
   logic [4:0]  shamt;
   logic        select_shamt;
   logic [31:0] alu_srcB;
   logic [31:0] alu_srcA;
   logic [31:0] alu_result;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        overflow;
   logic        alu_zero;
   logic        alu_done;
   logic        branch_en;
   logic        branch;
   logic [31:0] imm;
   logic [31:0] pc;
   logic [31:0] pc_out;
   logic        branch_done;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_branch_exec dut (
      .clk          (clk),
      .rst          (rst),
      .alu_en       (alu_en),
      .alu_control  (alu_control),
      .read_data1   (read_data1),
      .shamt        (shamt),
      .select_shamt (select_shamt),
      .alu_srcB     (alu_srcB),
      .alu_srcA     (alu_srcA),
      .alu_result   (alu_result),
      .hi           (hi),
      .lo           (lo),
      .overflow     (overflow),
      .alu_zero     (alu_zero),
      .alu_done     (alu_done),
      .branch_en    (branch_en),
      .branch       (branch),
      .imm          (imm),
      .pc           (pc),
      .pc_out       (pc_out),
      .branch_done  (branch_done)
   );

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Set up the ALU operands and opcode for the next enabled edge.
   task automatic applyStimulus(input logic [3:0] op, input logic sel, input logic [4:0] sh,
                                input logic [31:0] a, input logic [31:0] b, input logic en);
      alu_control  = op;
      select_shamt = sel;
      shamt        = sh;
      read_data1   = a;
      alu_srcB     = b;
      alu_en       = en;
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst       = 1'b1;
      branch_en = 1'b0;
      branch    = 1'b0;
      imm       = '0;
      pc        = '0;
      applyStimulus(4'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
      #2;
      checkOutput("reset_result", alu_result, 32'h0);
      checkOutput("reset_done", {alu_done, branch_done, overflow, alu_zero}, 32'h0);
      checkOutput("reset_pc_out", pc_out, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // ADD with signed overflow
      applyStimulus(4'd0, 1'b0, 5'd0, 32'h7FFF_FFFF, 32'h1, 1'b1);
      stepCycle();
      checkOutput("add_done", alu_done, 32'h1);
      checkOutput("add_result", alu_result, 32'h8000_0000);
      checkOutput("add_overflow", overflow, 32'h1);
      checkOutput("add_zero", alu_zero, 32'h0);
      alu_en = 1'b0;
      stepCycle();
      checkOutput("add_hold_done", alu_done, 32'h0);
      checkOutput("add_hold_result", alu_result, 32'h8000_0000);
      checkOutput("add_hold_ovf", overflow, 32'h1);

      // SLL using shamt, then using read_data1 low bits
      applyStimulus(4'd6, 1'b1, 5'd4, 32'hFFFF_FFFF, 32'h0000_000F, 1'b1);
      #1;
      checkOutput("srca_shamt", alu_srcA, 32'h4);
      stepCycle();
      checkOutput("sll_shamt", alu_result, 32'h0000_00F0);
      checkOutput("sll_ovf_clear", overflow, 32'h0);
      applyStimulus(4'd6, 1'b0, 5'd4, 32'h24, 32'h0000_000F, 1'b1);
      #1;
      checkOutput("srca_reg", alu_srcA, 32'h24);
      stepCycle();
      checkOutput("sll_reg", alu_result, 32'h0000_00F0);

      // Signed and unsigned multiply, then HI/LO hold across ADD
      applyStimulus(4'd11, 1'b0, 5'd0, 32'hFFFF_FFFE, 32'h3, 1'b1);
      stepCycle();
      checkOutput("mul_hi", hi, 32'hFFFF_FFFF);
      checkOutput("mul_lo", lo, 32'hFFFF_FFFA);
      checkOutput("mul_result", alu_result, 32'hFFFF_FFFA);
      applyStimulus(4'd0, 1'b0, 5'd0, 32'h1, 32'h2, 1'b1);
      stepCycle();
      checkOutput("add_after_mul", alu_result, 32'h3);
      checkOutput("hi_hold", hi, 32'hFFFF_FFFF);
      checkOutput("lo_hold", lo, 32'hFFFF_FFFA);
      applyStimulus(4'd12, 1'b0, 5'd0, 32'hFFFF_FFFE, 32'h3, 1'b1);
      stepCycle();
      checkOutput("mulu_hi", hi, 32'h2);
      checkOutput("mulu_lo", lo, 32'hFFFF_FFFA);

      // Remaining op patterns
      applyStimulus(4'd1, 1'b0, 5'd0, 32'h8000_0000, 32'h1, 1'b1);
      stepCycle();
      checkOutput("sub_result", alu_result, 32'h7FFF_FFFF);
      checkOutput("sub_overflow", overflow, 32'h1);
      applyStimulus(4'd8, 1'b0, 5'd0, 32'h4, 32'h8000_0000, 1'b1);
      stepCycle();
      checkOutput("sra", alu_result, 32'hF800_0000);
      checkOutput("sra_ovf", overflow, 32'h0);
      applyStimulus(4'd7, 1'b0, 5'd0, 32'h4, 32'h8000_0000, 1'b1);
      stepCycle();
      checkOutput("srl", alu_result, 32'h0800_0000);
      applyStimulus(4'd9, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h1, 1'b1);
      stepCycle();
      checkOutput("slt", alu_result, 32'h1);
      applyStimulus(4'd10, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h1, 1'b1);
      stepCycle();
      checkOutput("sltu", alu_result, 32'h0);
      checkOutput("sltu_zero", alu_zero, 32'h1);
      applyStimulus(4'd14, 1'b0, 5'd0, 32'h0, 32'h0000_1234, 1'b1);
      stepCycle();
      checkOutput("lui", alu_result, 32'h1234_0000);
      applyStimulus(4'd5, 1'b0, 5'd0, 32'h0F0F_0000, 32'h0000_00F0, 1'b1);
      stepCycle();
      checkOutput("nor", alu_result, 32'hF0F0_FF0F);
      applyStimulus(4'd4, 1'b0, 5'd0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1);
      stepCycle();
      checkOutput("xor", alu_result, 32'hF0F0_F0F0);

      // beq taken with a backward offset
      applyStimulus(4'd1, 1'b0, 5'd0, 32'h5, 32'h5, 1'b1);
      stepCycle();
      checkOutput("beq_zero", alu_zero, 32'h1);
      alu_en    = 1'b0;
      branch_en = 1'b1;
      branch    = 1'b1;
      pc        = 32'd10;
      imm       = 32'hFFFF_FFFD;
      stepCycle();
      checkOutput("beq_done", branch_done, 32'h1);
      checkOutput("beq_pc", pc_out, 32'd7);
      branch_en = 1'b0;

      // bne with equal operands: not taken
      applyStimulus(4'd13, 1'b0, 5'd0, 32'h9, 32'h9, 1'b1);
      stepCycle();
      checkOutput("bdone_drop", branch_done, 32'h0);
      checkOutput("beq_pc_hold", pc_out, 32'd7);
      checkOutput("sne_result", alu_result, 32'h1);
      checkOutput("sne_zero", alu_zero, 32'h0);
      alu_en    = 1'b0;
      branch_en = 1'b1;
      pc        = 32'd20;
      imm       = 32'd4;
      stepCycle();
      checkOutput("bne_not_taken", pc_out, 32'd20);

      // Zero flag set but not a branch, then a taken branch
      branch_en = 1'b0;
      applyStimulus(4'd13, 1'b0, 5'd0, 32'h9, 32'h8, 1'b1);
      stepCycle();
      checkOutput("sne_ne_zero", alu_zero, 32'h1);
      alu_en    = 1'b0;
      branch_en = 1'b1;
      branch    = 1'b0;
      pc        = 32'd30;
      imm       = 32'd4;
      stepCycle();
      checkOutput("nobranch_pc", pc_out, 32'd30);
      branch = 1'b1;
      stepCycle();
      checkOutput("bne_taken", pc_out, 32'd34);

      // Simultaneous enables: branch sees the zero flag from before the edge
      applyStimulus(4'd1, 1'b0, 5'd0, 32'h1, 32'h2, 1'b1);
      pc  = 32'd40;
      imm = 32'd2;
      stepCycle();
      checkOutput("sim_pc", pc_out, 32'd42);
      checkOutput("sim_zero", alu_zero, 32'h0);
      checkOutput("sim_result", alu_result, 32'hFFFF_FFFF);

      // Asynchronous reset while both units are enabled
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_result", alu_result, 32'h0);
      checkOutput("rst_hilo", hi | lo, 32'h0);
      checkOutput("rst_pc", pc_out, 32'h0);
      checkOutput("rst_flags", {alu_done, branch_done, overflow, alu_zero}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_branch_exec.md
Name: alu_branch_exec

Overview:
- Execute-stage block of the multi-cycle MIPS core.
- Contains:
  - the ALU source-A select (register vs. zero-extended shamt);
  - a registered 32-bit ALU with HI/LO multiply result and zero/overflow flags;
  - the branch-target unit that produces the next PC from the ALU zero flag.
- Driven by the control FSM with level enables; each unit returns a done flag.

Parameters:
- WIDTH, 32, datapath width of operands, result, PC and immediate.
- CTRL_W, 4, width of the ALU operation code.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- alu_en  in  1  ALU enable (level).
- alu_control  in  CTRL_W  operation code.
- read_data1  in  WIDTH  rs register value.
- shamt  in  5  instruction shift amount.
- select_shamt  in  1  1 = srcA is shamt, 0 = srcA is read_data1.
- alu_srcB  in  WIDTH  rt value or extended immediate, already muxed upstream.
- alu_srcA  out  WIDTH  combinational selected source A (observability).
- alu_result  out  WIDTH  registered result.
- hi  out  WIDTH  registered upper product word.
- lo  out  WIDTH  registered lower product word.
- overflow  out  1  registered signed overflow.
- alu_zero  out  1  registered (alu_result == 0).
- alu_done  out  1  ALU result valid.
- branch_en  in  1  branch unit enable (level).
- branch  in  1  decoded instruction is a branch.
- imm  in  WIDTH  sign-extended word offset.
- pc  in  WIDTH  word-indexed PC, already incremented (PC+1).
- pc_out  out  WIDTH  registered next PC.
- branch_done  out  1  pc_out valid.

Behaviour:
- Reset (async, rst=1): alu_result, hi, lo, pc_out = 0; overflow, alu_zero, alu_done, branch_done = 0.
- srcA mux (combinational):
  - alu_srcA = select_shamt ? {27'b0, shamt} : read_data1.
- ALU opcodes (A = alu_srcA, B = alu_srcB):
  - 0 ADD: A+B, overflow = signed overflow.
  - 1 SUB: A-B, overflow = signed overflow.
  - 2 AND; 3 OR; 4 XOR; 5 NOR.
  - 6 SLL: B << A[4:0].
  - 7 SRL: logical B >> A[4:0].
  - 8 SRA: arithmetic B >>> A[4:0].
  - 9 SLT: signed A<B ? 1 : 0.
  - 10 SLTU: unsigned A<B ? 1 : 0.
  - 11 MUL: signed 64-bit product, {hi,lo} = product, result = low word.
  - 12 MULU: unsigned product, same placement.
  - 13 SNE: (A==B) ? 1 : 0, so alu_zero=1 when A!=B; used for bne.
  - 14 LUI: B << 16.
  - 15 PASSB: B.
  - Overflow is 0 for every op except ADD/SUB. All arithmetic is modulo 2^WIDTH.
- hi/lo are written only by ops 11/12 and otherwise hold their value.
- ALU handshake:
  - Each rising edge with alu_en=1: register result and flags from current inputs; alu_done <= 1.
  - alu_done first asserts one cycle after alu_en rises, and stays 1 while alu_en=1, with results recomputed each edge.
  - Edge with alu_en=0: alu_done <= 0; result, hi, lo and flags hold their last values. The FSM reads them in later states (MEMORY, REGWRITE, BRANCH).
- Branch unit:
  - Each rising edge with branch_en=1: pc_out <= (branch & alu_zero) ? pc + imm : pc; branch_done <= 1.
  - branch_en=0: branch_done <= 0; pc_out holds.
  - Target arithmetic wraps modulo 2^WIDTH; a negative imm moves backward.
  - alu_zero is the registered flag from the preceding EXECUTE; beq uses SUB, bne uses SNE.
- Simultaneous alu_en and branch_en: both units update independently. Branch uses the alu_zero value from before this edge.
- Reset mid-operation: all registers clear immediately; done flags drop; no partial result is retained.

Decomposition:
- Shared package: ALU opcode constants (ALU_ADD … ALU_PASSB), WIDTH default, shift-amount width (5).
- Sub-module alu_core: registered ALU with the handshake.
- srcA mux and branch unit are small enough to live in the top.

Test Plan:
- ADD: A=0x7FFFFFFF, B=1, alu_en for 1 cycle → next cycle alu_done=1, result=0x80000000, overflow=1, alu_zero=0; after alu_en=0, result holds and done=0.
- SLL via shamt: select_shamt=1, shamt=4, B=0x0000000F, op 6 → result=0x000000F0. Then select_shamt=0, read_data1=0x24 (A[4:0]=4), same op → result=0x000000F0.
- MUL: A=0xFFFFFFFE (-2), B=3, op 11 → hi=0xFFFFFFFF, lo=result=0xFFFFFFFA. A following ADD leaves hi/lo unchanged.
- beq taken: SUB A=B=5 → alu_zero=1. Then branch=1, pc=10, imm=0xFFFFFFFD, branch_en → branch_done=1, pc_out=7.
- bne not taken: SNE A=B=9 → result=1, alu_zero=0. Branch with pc=20, imm=4 → pc_out=20. branch=0 with alu_zero=1 → pc_out=pc.
- Reset: assert rst asynchronously while alu_en=1 and branch_en=1 → all outputs 0 immediately, without waiting for a clock edge.
